rc_servo_track_nch: RTL and testbench

RC_SERVO_TRACK_NCH -- requirements
Module: rc_servo_track_nch

---
 rtl/rc_servo_pkg.sv | 18 +
 rtl/rc_servo_chan.sv | 81 ++++++++
 rtl/rc_servo_track_nch.sv | 88 ++++++++
 tb/tb_rc_servo_track_nch.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/rc_servo_pkg.sv
// Shared timing defaults, width type and vote helper for the servo tracker.
package rc_servo_pkg;

    localparam int unsigned DEF_W            = 16;
    localparam int unsigned DEF_TICK_DIV     = 50;
    localparam int unsigned DEF_FRAME_TICKS  = 20000;
    localparam int unsigned DEF_MIN_TICKS    = 1000;
    localparam int unsigned DEF_CENTER_TICKS = 1500;
    localparam int unsigned DEF_MAX_TICKS    = 2000;
    localparam int unsigned DEF_STEP         = 4;

    typedef logic [DEF_W-1:0] width_t;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/rc_servo_chan.sv
// One tracking channel: comparator synchroniser, 3-tick vote history,
// clamped pulse-width register and registered PWM compare.
module rc_servo_chan
    import rc_servo_pkg::*;
#(
    parameter int unsigned W            = DEF_W,
    parameter int unsigned MIN_TICKS    = DEF_MIN_TICKS,
    parameter int unsigned CENTER_TICKS = DEF_CENTER_TICKS,
    parameter int unsigned MAX_TICKS    = DEF_MAX_TICKS,
    parameter int unsigned STEP         = DEF_STEP
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         comp_async_i,
    input  logic         en_i,
    input  logic         hold_i,
    input  logic         tick_i,
    input  logic         frame_end_i,
    input  logic [W-1:0] frame_count_i,
    output logic         pwm_o,
    output logic [W-1:0] width_o
);

    localparam logic [W-1:0] CenterT = W'(CENTER_TICKS);
    localparam logic [W:0]   MinX    = (W+1)'(MIN_TICKS);
    localparam logic [W:0]   MaxX    = (W+1)'(MAX_TICKS);
    localparam logic [W:0]   StepX   = (W+1)'(STEP);

    logic [1:0]   sync_q, sync_d;
    logic [2:0]   hist_q, hist_d;
    logic [W-1:0] width_q, width_d;
    logic         pwm_q, pwm_d;
    logic         vote;
    logic [W:0]   width_ext, up_sum, dn_diff;

    // Vote is taken from the history as it stands before this cycle's shift.
    assign vote      = maj3(hist_q);
    assign width_ext = {1'b0, width_q};
    assign up_sum    = width_ext + StepX;
    assign dn_diff   = width_ext - StepX;

    always_comb begin
        sync_d  = {sync_q[0], comp_async_i};
        hist_d  = hist_q;
        width_d = width_q;
        pwm_d   = en_i & (frame_count_i < width_q);

        if (tick_i) begin
            hist_d = {hist_q[1:0], sync_q[1]};
        end

        if (!en_i) begin
            width_d = CenterT;
        end else if (frame_end_i && !hold_i) begin
            if (vote) begin
                width_d = (up_sum > MaxX) ? MaxX[W-1:0] : up_sum[W-1:0];
            end else begin
                // dn_diff is only taken when it cannot underflow.
                width_d = (width_ext < MinX + StepX) ? MinX[W-1:0] : dn_diff[W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q  <= '0;
            hist_q  <= '0;
            width_q <= CenterT;
            pwm_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            width_q <= width_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_o   = pwm_q;
    assign width_o = width_q;

endmodule

// File: rtl/rc_servo_track_nch.sv
// Multi-channel RC servo tracker: shared tick prescaler and frame timebase
// driving NUM_CH independent comparator-steered pulse-width channels.
module rc_servo_track_nch
    import rc_servo_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned W            = DEF_W,
    parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
    parameter int unsigned FRAME_TICKS  = DEF_FRAME_TICKS,
    parameter int unsigned MIN_TICKS    = DEF_MIN_TICKS,
    parameter int unsigned CENTER_TICKS = DEF_CENTER_TICKS,
    parameter int unsigned MAX_TICKS    = DEF_MAX_TICKS,
    parameter int unsigned STEP         = DEF_STEP
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [NUM_CH-1:0]   comp_async_i,
    input  logic [NUM_CH-1:0]   ch_en_i,
    input  logic                hold_i,
    output logic [NUM_CH-1:0]   pwm_o,
    output logic [NUM_CH*W-1:0] pos_o,
    output logic                frame_start_o
);

    if (!(MIN_TICKS <= CENTER_TICKS && CENTER_TICKS <= MAX_TICKS &&
          MAX_TICKS < FRAME_TICKS && FRAME_TICKS < (64'd1 << W) &&
          STEP >= 1 && TICK_DIV >= 1 && NUM_CH >= 1 && NUM_CH <= 8)) begin : g_param_check
        $error("rc_servo_track_nch: inconsistent timing parameters");
    end

    localparam int unsigned     PreW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PreW-1:0] PreLast   = PreW'(TICK_DIV - 1);
    localparam logic [W-1:0]    FrameLast = W'(FRAME_TICKS - 1);

    logic [PreW-1:0] pre_q, pre_d;
    logic [W-1:0]    frame_q, frame_d;
    logic            frame_start_q, frame_start_d;
    logic            tick, frame_end;

    assign tick      = (pre_q == PreLast);
    assign frame_end = tick && (frame_q == FrameLast);

    always_comb begin
        pre_d   = tick ? '0 : pre_q + PreW'(1);
        frame_d = frame_q;
        if (tick) begin
            frame_d = frame_end ? '0 : frame_q + W'(1);
        end
        // Registered from the wrap itself, so the post-reset frame gets no pulse.
        frame_start_d = frame_end;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pre_q         <= '0;
            frame_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            frame_q       <= frame_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_start_o = frame_start_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        rc_servo_chan #(
            .W            (W),
            .MIN_TICKS    (MIN_TICKS),
            .CENTER_TICKS (CENTER_TICKS),
            .MAX_TICKS    (MAX_TICKS),
            .STEP         (STEP)
        ) u_chan (
            .clk_i         (clk_i),
            .reset_i       (reset_i),
            .comp_async_i  (comp_async_i[i]),
            .en_i          (ch_en_i[i]),
            .hold_i        (hold_i),
            .tick_i        (tick),
            .frame_end_i   (frame_end),
            .frame_count_i (frame_q),
            .pwm_o         (pwm_o[i]),
            .width_o       (pos_o[i*W +: W])
        );
    end

endmodule

// File: tb/tb_rc_servo_track_nch.sv
// Frame-level directed bench for rc_servo_track_nch with a small timebase.
module tb_rc_servo_track_nch;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned W      = 16;
    localparam int unsigned FRAME  = 40;  // clk cycles per frame (20 ticks x 2)

    logic                clk = 1'b0;
    logic                reset;
    logic [NUM_CH-1:0]   comp_async;
    logic [NUM_CH-1:0]   ch_en;
    logic                hold;
    logic [NUM_CH-1:0]   pwm;
    logic [NUM_CH*W-1:0] pos;
    logic                frame_start;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] comp;
        logic [1:0] en;
        logic       hold;
        int         hi0;
        int         hi1;
        int         pos0;
        int         pos1;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    rc_servo_track_nch #(
        .NUM_CH       (NUM_CH),
        .W            (W),
        .TICK_DIV     (2),
        .FRAME_TICKS  (20),
        .MIN_TICKS    (4),
        .CENTER_TICKS (8),
        .MAX_TICKS    (12),
        .STEP         (3)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .comp_async_i  (comp_async),
        .ch_en_i       (ch_en),
        .hold_i        (hold),
        .pwm_o         (pwm),
        .pos_o         (pos),
        .frame_start_o (frame_start)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drives inputs for n cycles starting at a frame boundary; optional
    // 2-cycle glitch on comp bit 0 starting at cycle glitch_at.
    task automatic run_window(input logic [1:0] c, input logic [1:0] e, input logic h,
                              input int glitch_at, input int n,
                              output int hi0, output int hi1,
                              output int fs_cnt, output int fs_last);
        hi0 = 0; hi1 = 0; fs_cnt = 0; fs_last = 0;
        for (int k = 0; k < n; k++) begin
            comp_async = c;
            if (glitch_at >= 0 && (k == glitch_at || k == glitch_at + 1)) begin
                comp_async = c ^ 2'b01;
            end
            ch_en = e;
            hold  = h;
            @(posedge clk);
            #1;
            hi0     += int'(pwm[0]);
            hi1     += int'(pwm[1]);
            fs_cnt  += int'(frame_start);
            fs_last  = int'(frame_start);
        end
    endtask

    task automatic check_reset_cycles(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s pwm c%0d", tag, k), int'(pwm), 0);
            chk($sformatf("%s fs c%0d", tag, k), int'(frame_start), 0);
            chk($sformatf("%s pos0 c%0d", tag, k), int'(pos[W-1:0]), 8);
            chk($sformatf("%s pos1 c%0d", tag, k), int'(pos[2*W-1:W]), 8);
        end
    endtask

    task automatic check_frame(input string tag, input int hi0, input int hi1,
                               input int fs_cnt, input int fs_last,
                               input int e_hi0, input int e_hi1,
                               input int e_pos0, input int e_pos1);
        chk({tag, " hi0"}, hi0, e_hi0);
        chk({tag, " hi1"}, hi1, e_hi1);
        chk({tag, " pos0"}, int'(pos[W-1:0]), e_pos0);
        chk({tag, " pos1"}, int'(pos[2*W-1:W]), e_pos1);
        chk({tag, " fs_cnt"}, fs_cnt, 1);
        chk({tag, " fs_last"}, fs_last, 1);
    endtask

    initial begin
        int hi0, hi1, fs_cnt, fs_last;

        // comp, en, hold, pwm-high cycles ch0/ch1 in this frame, widths at frame end
        vecs[0] = '{2'b01, 2'b11, 1'b0, 16, 16, 11,  5};
        vecs[1] = '{2'b01, 2'b11, 1'b0, 22, 10, 12,  4};
        vecs[2] = '{2'b01, 2'b11, 1'b0, 24,  8, 12,  4};
        vecs[3] = '{2'b10, 2'b11, 1'b1, 24,  8, 12,  4};
        vecs[4] = '{2'b10, 2'b11, 1'b0, 24,  8,  9,  7};
        vecs[5] = '{2'b10, 2'b01, 1'b0, 18,  0,  6,  8};
        vecs[6] = '{2'b00, 2'b11, 1'b0, 12, 16,  4,  5};
        vecs[7] = '{2'b11, 2'b11, 1'b0,  8, 10,  7,  8};

        reset      = 1'b1;
        comp_async = 2'b00;
        ch_en      = 2'b11;
        hold       = 1'b0;
        check_reset_cycles("reset", 3);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_window(vecs[i].comp, vecs[i].en, vecs[i].hold, -1, FRAME,
                       hi0, hi1, fs_cnt, fs_last);
            check_frame($sformatf("vec%0d", i), hi0, hi1, fs_cnt, fs_last,
                        vecs[i].hi0, vecs[i].hi1, vecs[i].pos0, vecs[i].pos1);
        end

        // Single-tick glitch lands in the final history window: vote stays 0.
        run_window(2'b00, 2'b11, 1'b0, 33, FRAME, hi0, hi1, fs_cnt, fs_last);
        check_frame("glitch", hi0, hi1, fs_cnt, fs_last, 14, 16, 4, 5);

        // Run to frame count 10, then reset mid-frame.
        run_window(2'b00, 2'b11, 1'b0, -1, 21, hi0, hi1, fs_cnt, fs_last);
        chk("pre-abort hi0", hi0, 8);
        chk("pre-abort hi1", hi1, 10);
        chk("pre-abort fs", fs_cnt, 0);
        reset = 1'b1;
        check_reset_cycles("midreset", 3);
        reset = 1'b0;
        run_window(2'b00, 2'b11, 1'b0, -1, FRAME, hi0, hi1, fs_cnt, fs_last);
        check_frame("after_reset", hi0, hi1, fs_cnt, fs_last, 16, 16, 5, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
